// File: rtl/sdhci_card_cmd.sv
// ---------------------------------------------------------------------------
// sdhci_card_cmd
//   Card-side SD CMD line engine. Receives 48-bit host commands (start,
//   transmission bit, index, argument, CRC7, end bit), checks them and hands
//   index/argument to card logic over a valid/ready port. It then takes a
//   response from card logic and serialises a 48-bit short reply (with or
//   without CRC7) or a 136-bit R2 reply back onto the CMD line.
//   sd_clk_i is sampled as data in the clk_i domain: the line is sampled on
//   sd_clk rises and driven on sd_clk falls.
//
// Ports
//   clk_i, rst_ni            system clock, async active-low reset
//   sd_clk_i, sd_cmd_i       SD clock and CMD line as seen by the card
//   sd_cmd_o, sd_cmd_en_o    card CMD drive value / output enable
//   cmd_valid_o/ready_i      received command handshake
//   cmd_index_o, cmd_arg_o   received command fields
//   rsp_valid_i/ready_o      response handshake
//   rsp_kind_i               0 none, 1 short+CRC, 2 short no-CRC, 3 long
//   rsp_data_i               short: [37:0] index/arg, long: [127:8] payload
//   crc_err_o                pulse: command dropped (CRC7 or end bit)
//   timeout_o                pulse: no response within NcrMax sd_clk rises
// ---------------------------------------------------------------------------
module sdhci_card_cmd #(
   parameter int NcrMin = 2,
   parameter int NcrMax = 64
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         sd_clk_i,
   input  logic         sd_cmd_i,
   output logic         sd_cmd_o,
   output logic         sd_cmd_en_o,
   output logic         cmd_valid_o,
   input  logic         cmd_ready_i,
   output logic [5:0]   cmd_index_o,
   output logic [31:0]  cmd_arg_o,
   input  logic         rsp_valid_i,
   output logic         rsp_ready_o,
   input  logic [1:0]   rsp_kind_i,
   input  logic [127:0] rsp_data_i,
   output logic         crc_err_o,
   output logic         timeout_o
);

   localparam int NW = $clog2(NcrMax + 1);
   localparam logic [NW-1:0] NCR_MIN  = NW'(NcrMin);
   localparam logic [NW-1:0] NCR_LAST = NW'(NcrMax - 1);
   localparam logic [NW-1:0] NCR_SAT  = NW'(NcrMax);

   typedef enum logic [2:0] {
      IDLE, RECV, HAND, WAIT, LOAD, SEND
   } state_e;

   // One CRC7 (x^7 + x^3 + 1) step, MSB-first data.
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:3], c[2] ^ fb, c[1:0], fb};
   endfunction

   // CRC7 over 120 bits. Leading zeros leave a zero-initialised CRC at zero,
   // so shorter messages are right-aligned and zero-padded.
   function automatic logic [6:0] crc7_calc(input logic [119:0] d);
      logic [6:0] c;
      c = '0;
      for (int i = 119; i >= 0; i--) c = crc7_step(c, d[i]);
      return c;
   endfunction

   state_e          state;
   logic            sd_clk_q;
   logic            rise, fall;
   logic [7:0]      bit_cnt;
   logic [44:0]     rx_sr;     // frame bits 45..1 once the end bit arrives
   logic [6:0]      rx_crc;
   logic [NW-1:0]   ncr;       // sd_clk rises since the command end bit
   logic [135:0]    tx_sr;     // reply, MSB-aligned
   logic [135:0]    tx_load;
   logic [7:0]      tx_last;
   logic [6:0]      crc_short, crc_long;
   logic            accept, ncr_expire;
   logic            unused_rsp;

   assign rise = sd_clk_i & ~sd_clk_q;
   assign fall = ~sd_clk_i & sd_clk_q;

   assign accept     = (state == WAIT) & rsp_valid_i & rsp_ready_o;
   assign ncr_expire = rise & (ncr == NCR_LAST) &
                       ((state == HAND) | ((state == WAIT) & ~accept));

   assign unused_rsp = ^rsp_data_i[7:0];

   always_comb begin
      crc_short = crc7_calc({82'b0, rsp_data_i[37:0]});
      crc_long  = crc7_calc(rsp_data_i[127:8]);
      tx_load   = '0;
      tx_last   = 8'd47;
      case (rsp_kind_i)
         2'd3: begin
            tx_load = {2'b00, 6'h3F, rsp_data_i[127:8], crc_long, 1'b1};
            tx_last = 8'd135;
         end
         2'd2:    tx_load = {2'b00, rsp_data_i[37:0], 7'h7F, 1'b1, 88'b0};
         default: tx_load = {2'b00, rsp_data_i[37:0], crc_short, 1'b1, 88'b0};
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         sd_clk_q    <= 1'b0;
         bit_cnt     <= '0;
         rx_sr       <= '0;
         rx_crc      <= '0;
         ncr         <= '0;
         tx_sr       <= '0;
         sd_cmd_o    <= 1'b1;
         sd_cmd_en_o <= 1'b0;
         cmd_valid_o <= 1'b0;
         cmd_index_o <= '0;
         cmd_arg_o   <= '0;
         rsp_ready_o <= 1'b0;
         crc_err_o   <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         sd_clk_q  <= sd_clk_i;
         crc_err_o <= 1'b0;
         timeout_o <= 1'b0;

         // Ncr keeps counting through HAND/WAIT/LOAD; saturate so LOAD can
         // never wrap below NcrMin.
         if ((state == HAND || state == WAIT || state == LOAD) && rise && ncr != NCR_SAT)
            ncr <= ncr + 1'b1;

         if (ncr_expire) begin
            // Response window closed: drop the pending command entirely.
            timeout_o   <= 1'b1;
            cmd_valid_o <= 1'b0;
            rsp_ready_o <= 1'b0;
            state       <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (rise && !sd_cmd_i) begin
                     state   <= RECV;
                     bit_cnt <= 8'd1;
                     rx_crc  <= '0;   // start bit is 0: contributes nothing
                  end
               end

               RECV: begin
                  if (rise) begin
                     rx_sr   <= {rx_sr[43:0], sd_cmd_i};
                     bit_cnt <= bit_cnt + 8'd1;
                     if (bit_cnt <= 8'd39)   // frame bits 46..8
                        rx_crc <= crc7_step(rx_crc, sd_cmd_i);
                     if (bit_cnt == 8'd1 && !sd_cmd_i) begin
                        state <= IDLE;       // not a host-to-card frame
                     end else if (bit_cnt == 8'd47) begin
                        if (sd_cmd_i && rx_crc == rx_sr[6:0]) begin
                           cmd_index_o <= rx_sr[44:39];
                           cmd_arg_o   <= rx_sr[38:7];
                           cmd_valid_o <= 1'b1;
                           ncr         <= '0;
                           state       <= HAND;
                        end else begin
                           crc_err_o <= 1'b1;
                           state     <= IDLE;
                        end
                     end
                  end
               end

               HAND: begin
                  if (cmd_ready_i) begin
                     cmd_valid_o <= 1'b0;
                     rsp_ready_o <= 1'b1;
                     state       <= WAIT;
                  end
               end

               WAIT: begin
                  if (accept) begin
                     rsp_ready_o <= 1'b0;
                     if (rsp_kind_i == 2'd0) begin
                        state <= IDLE;
                     end else begin
                        tx_sr   <= tx_load;
                        bit_cnt <= tx_last;
                        state   <= LOAD;
                     end
                  end
               end

               LOAD: begin
                  if (fall && ncr >= NCR_MIN) begin
                     sd_cmd_en_o <= 1'b1;
                     sd_cmd_o    <= tx_sr[135];
                     tx_sr       <= {tx_sr[134:0], 1'b0};
                     state       <= SEND;
                  end
               end

               SEND: begin
                  // bit_cnt = bits still to drive; at zero the end bit has
                  // been on the line a full period, so release.
                  if (fall) begin
                     if (bit_cnt != 8'd0) begin
                        sd_cmd_o <= tx_sr[135];
                        tx_sr    <= {tx_sr[134:0], 1'b0};
                        bit_cnt  <= bit_cnt - 8'd1;
                     end else begin
                        sd_cmd_en_o <= 1'b0;
                        sd_cmd_o    <= 1'b1;
                        state       <= IDLE;
                     end
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sdhci_card_cmd.sv
// ---------------------------------------------------------------------------
// tb_sdhci_card_cmd
//   Directed and randomized bench for sdhci_card_cmd. The bench plays host
//   (drives sd_clk/CMD), logs the card's line at every sd_clk rise and
//   compares against frames built from a polynomial-division CRC7 model.
// ---------------------------------------------------------------------------
module tb_sdhci_card_cmd;

   localparam int NCR_MIN = 2;
   localparam int NCR_MAX = 64;
   localparam int HALF    = 3;   // clk_i cycles per sd_clk half period

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         sd_clk_i = 1'b0;
   logic         sd_cmd_i = 1'b1;
   logic         sd_cmd_o, sd_cmd_en_o;
   logic         cmd_valid_o;
   logic         cmd_ready_i = 1'b0;
   logic [5:0]   cmd_index_o;
   logic [31:0]  cmd_arg_o;
   logic         rsp_valid_i = 1'b0;
   logic         rsp_ready_o;
   logic [1:0]   rsp_kind_i = 2'd0;
   logic [127:0] rsp_data_i = '0;
   logic         crc_err_o, timeout_o;

   sdhci_card_cmd #(.NcrMin(NCR_MIN), .NcrMax(NCR_MAX)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .sd_clk_i(sd_clk_i), .sd_cmd_i(sd_cmd_i),
      .sd_cmd_o(sd_cmd_o), .sd_cmd_en_o(sd_cmd_en_o),
      .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
      .cmd_index_o(cmd_index_o), .cmd_arg_o(cmd_arg_o),
      .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
      .rsp_kind_i(rsp_kind_i), .rsp_data_i(rsp_data_i),
      .crc_err_o(crc_err_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int n_pass = 0, n_total = 0, n_fail = 0;
   int rise_no = 0;
   logic log_en [0:255];
   logic log_bit[0:255];

   // card-logic observations
   int got_cnt = 0, crc_cnt = 0, to_cnt = 0, acc_cnt = 0, to_rise = -1;
   logic [5:0]  got_idx = '0;
   logic [31:0] got_arg = '0;

   initial begin
      forever begin
         @(negedge clk_i);
         if (cmd_valid_o && cmd_ready_i) begin
            got_idx = cmd_index_o; got_arg = cmd_arg_o; got_cnt++;
         end
         if (rsp_valid_i && rsp_ready_o) acc_cnt++;
         if (crc_err_o) crc_cnt++;
         if (timeout_o) begin to_cnt++; to_rise = rise_no; end
      end
   end

   // ---- reference model ----------------------------------------------------
   // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1 (0x89).
   function automatic logic [6:0] m_crc7(input logic [119:0] msg);
      logic [127:0] a;
      a = {1'b0, msg, 7'b0};
      for (int i = 126; i >= 7; i--)
         if (a[i]) a[i -: 8] = a[i -: 8] ^ 8'h89;
      return a[6:0];
   endfunction

   function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b01, idx, arg, m_crc7({80'b0, 2'b01, idx, arg}), 1'b1};
   endfunction

   function automatic logic [135:0] m_reply(input logic [1:0] kind, input logic [127:0] d);
      case (kind)
         2'd1:    return {88'b0, 2'b00, d[37:0], m_crc7({82'b0, d[37:0]}), 1'b1};
         2'd2:    return {88'b0, 2'b00, d[37:0], 7'h7F, 1'b1};
         2'd3:    return {2'b00, 6'h3F, d[127:8], m_crc7(d[127:8]), 1'b1};
         default: return '0;
      endcase
   endfunction

   // ---- helpers -----------------------------------------------------------
   task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One sd_clk period: host bit on the fall, card line logged at the rise.
   task automatic tick(input logic b);
      sd_clk_i = 1'b0;
      sd_cmd_i = b;
      repeat (HALF) @(negedge clk_i);
      sd_clk_i = 1'b1;
      rise_no++;
      if (rise_no < 256) begin
         log_en[rise_no]  = sd_cmd_en_o;
         log_bit[rise_no] = sd_cmd_o;
      end
      repeat (HALF) @(negedge clk_i);
   endtask

   // After the frame, rise 1 is the first rise following the end bit.
   task automatic send_frame(input logic [47:0] f);
      for (int i = 47; i >= 0; i--) tick(f[i]);
      rise_no = 0;
      for (int i = 0; i < 256; i++) begin log_en[i] = 1'b0; log_bit[i] = 1'b1; end
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b1);
   endtask

   task automatic check_reply(input string tag, input int len, input logic [135:0] exp);
      int first, cnt;
      logic [135:0] vec;
      first = -1; cnt = 0; vec = '0;
      for (int i = 1; i < 256; i++)
         if (log_en[i]) begin
            if (first < 0) first = i;
            cnt++;
            vec = {vec[134:0], log_bit[i]};
         end
      if (len == 0) begin
         check({tag, " drive_cnt"}, 136'(cnt), 136'(0));
      end else begin
         check({tag, " start_rise"}, 136'(first), 136'(NCR_MIN + 1));
         check({tag, " drive_cnt"}, 136'(cnt), 136'(len));
         check({tag, " bits"}, vec, exp);
      end
   endtask

   // ---- stimulus ----------------------------------------------------------
   logic [5:0]   r_idx;
   logic [31:0]  r_arg;
   logic [1:0]   r_kind;
   logic [127:0] r_data;
   logic [47:0]  frm;
   logic [135:0] e_long;
   int           pos, g0, c0, a0, t0;

   initial begin
      repeat (3) @(negedge clk_i);
      check("reset_state",
            {sd_cmd_o, sd_cmd_en_o, cmd_valid_o, rsp_ready_o, crc_err_o, timeout_o, cmd_index_o, cmd_arg_o},
            {1'b1, 5'b0, 6'b0, 32'b0});
      rst_ni = 1'b1;
      @(negedge clk_i);
      cmd_ready_i = 1'b1;
      rsp_valid_i = 1'b1;

      // CMD0, no response
      rsp_kind_i = 2'd0;
      g0 = got_cnt; a0 = acc_cnt;
      send_frame(48'h40_00000000_95);
      idle(20);
      check("cmd0 handshake", 136'(got_cnt), 136'(g0 + 1));
      check("cmd0 idx_arg", {got_idx, got_arg}, {6'd0, 32'd0});
      check("cmd0 rsp_accept", 136'(acc_cnt), 136'(a0 + 1));
      check_reply("cmd0", 0, '0);

      // CMD8, R7
      rsp_kind_i = 2'd1;
      rsp_data_i = {90'b0, 6'd8, 32'h1AA};
      send_frame(48'h48_000001AA_87);
      idle(NCR_MIN + 48 + 6);
      check("cmd8 idx_arg", {got_idx, got_arg}, {6'd8, 32'h1AA});
      check_reply("cmd8", 48, 136'(48'h08_000001AA_13));

      // corrupted arg bit and corrupted end bit
      g0 = got_cnt; c0 = crc_cnt;
      send_frame(48'h48_000001AB_87);
      idle(10);
      check("argflip crc_err", 136'(crc_cnt), 136'(c0 + 1));
      check_reply("argflip", 0, '0);
      send_frame(48'h48_000001AA_86);
      idle(10);
      check("endflip crc_err", 136'(crc_cnt), 136'(c0 + 2));
      check("flips no_cmd", 136'(got_cnt), 136'(g0));

      // transmission bit 0: silently ignored
      send_frame(48'h3F_FFFFFFFF_FF);
      idle(10);
      check("txbit0 no_pulse", 136'(crc_cnt), 136'(c0 + 2));
      check("txbit0 no_cmd", 136'(got_cnt), 136'(g0));
      check_reply("txbit0", 0, '0);

      // CMD2, R2 with zero payload
      rsp_kind_i = 2'd3;
      rsp_data_i = '0;
      e_long = '0;
      e_long[133:128] = 6'h3F;
      e_long[0] = 1'b1;
      send_frame(48'h42_00000000_4D);
      idle(NCR_MIN + 136 + 6);
      check("cmd2 idx", 136'(got_idx), 136'(2));
      check_reply("cmd2", 136, e_long);

      // randomized good frames
      for (int t = 0; t < 6; t++) begin
         r_idx  = 6'($urandom);
         r_arg  = $urandom;
         r_kind = 2'($urandom_range(1, 3));
         r_data = {$urandom, $urandom, $urandom, $urandom};
         rsp_kind_i = r_kind;
         rsp_data_i = r_data;
         send_frame(make_frame(r_idx, r_arg));
         idle(NCR_MIN + ((r_kind == 2'd3) ? 136 : 48) + 6);
         check($sformatf("rand%0d idx_arg", t), {r_idx, r_arg}, {got_idx, got_arg});
         check_reply($sformatf("rand%0d k%0d", t, r_kind), (r_kind == 2'd3) ? 136 : 48,
                     m_reply(r_kind, r_data));
      end

      // randomized single-bit corruption
      for (int t = 0; t < 4; t++) begin
         g0 = got_cnt; c0 = crc_cnt;
         frm = make_frame(6'($urandom), $urandom);
         pos = $urandom_range(1, 45);
         frm[pos] = ~frm[pos];
         send_frame(frm);
         idle(10);
         check($sformatf("bitflip%0d crc_err", t), 136'(crc_cnt), 136'(c0 + 1));
         check($sformatf("bitflip%0d no_cmd", t), 136'(got_cnt), 136'(g0));
      end

      // card logic never takes the command -> timeout
      cmd_ready_i = 1'b0;
      rsp_kind_i  = 2'd1;
      g0 = got_cnt; t0 = to_cnt;
      send_frame(48'h48_000001AA_87);
      idle(NCR_MAX + 4);
      check("timeout pulse", 136'(to_cnt), 136'(t0 + 1));
      check("timeout rise", 136'(to_rise), 136'(NCR_MAX));
      check("timeout valid_drop", 136'(cmd_valid_o), 136'(0));
      check_reply("timeout", 0, '0);
      cmd_ready_i = 1'b1;
      rsp_kind_i  = 2'd0;
      send_frame(48'h77_00000000_65);
      idle(10);
      check("cmd55 handshake", 136'(got_cnt), 136'(g0 + 1));
      check("cmd55 idx_arg", {got_idx, got_arg}, {6'd55, 32'd0});

      // reset while the reply is on the line
      rsp_kind_i = 2'd1;
      rsp_data_i = {90'b0, 6'd8, 32'h1AA};
      send_frame(48'h48_000001AA_87);
      idle(NCR_MIN + 1 + 20);
      check("presend en", 136'(sd_cmd_en_o), 136'(1));
      rst_ni = 1'b0;
      #1;
      check("abort line", {sd_cmd_en_o, sd_cmd_o, cmd_valid_o}, {1'b0, 1'b1, 1'b0});
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      rsp_kind_i = 2'd0;
      g0 = got_cnt;
      send_frame(48'h40_00000000_95);
      idle(10);
      check("post_reset handshake", 136'(got_cnt), 136'(g0 + 1));
      check("post_reset idx_arg", {got_idx, got_arg}, {6'd0, 32'd0});
      check_reply("post_reset", 0, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
